seq_priority_encoder: RTL and testbench
=======================================

Name: seq_priority_encoder

Overview:
- Parametrised, sequential successor to the 4-to-2 encoder.
- Accepts an N-bit request vector through a valid/ready handshake.
- Emits the binary index of every set bit, one per output handshake, lowest index first.
- Drives per-burst popcount and last/zero flags; serves as the index serializer for interrupt and request-scan logic.

Parameters:
- N, 8, request vector width (>= 2).
- W, $clog2(N) (localparam, not overridable), index width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request vector present.
- in_ready  output  1  block can accept a vector.
- in_vec  input  N  request vector.
- out_valid  output  1  out_idx/out_last/out_zero/out_cnt valid.
- out_ready  input  1  consumer accepts current beat.
- out_idx  output  W  binary index of current set bit.
- out_last  output  1  current beat is final beat of burst.
- out_zero  output  1  accepted vector was all zeros.
- out_cnt  output  W+1  popcount of accepted vector, stable for whole burst.

Behaviour:
- Reset (async assert, sync-to-clk deassert by the environment):
  - state=IDLE, pending=0, out_cnt=0, zero flag=0.
  - in_ready=1, out_valid=0, out_idx=0, out_last=0, out_zero=0.
- Clock and reset: one clock domain, clk only; rst acts asynchronously at any time.
- Input handshake: transfer on in_valid && in_ready at a rising edge. in_ready=1 only in IDLE.
- State IDLE:
  - On accept: pending<=in_vec; out_cnt<=popcount(in_vec); zero flag<=(in_vec==0); go to SCAN.
  - in_vec is don't-care when not accepted.
- State SCAN:
  - in_ready=0; out_valid=1.
  - out_idx = index of lowest set bit of pending, combinational from registered pending.
  - out_last=1 when pending has exactly one set bit.
- Zero vector in SCAN: out_zero=1, out_idx=0, out_last=1, out_cnt=0; one beat only.
- Output handshake: transfer on out_valid && out_ready.
  - On transfer, clear the bit at out_idx in pending.
  - If out_last, go to IDLE: pending=0, out_cnt held at last value, out_zero=0.
  - out_ready low: all outputs held stable; no bit cleared.
- Latency and throughput:
  - First beat valid in the cycle after input accept.
  - One beat per cycle while out_ready=1.
  - Burst of k set bits takes k output cycles, then 1 IDLE cycle before the next accept. No accept-on-last-beat bypass.
- Popcount: W+1 bits, so value N (all ones) is representable.
- Widths: in_vec bit N-1 maps to index N-1. Non-power-of-two N supported; unused index codes are never produced.
- Simultaneous events: in_valid during SCAN is ignored (in_ready=0), and the vector must be held by the source.
- Reset mid-burst: immediate return to reset values; remaining bits discarded, no further beats.

Optional Feature:
- Macro: SEQ_PRIORITY_ENCODER_MSB_FIRST_EN.
- Defined: scan order reversed; out_idx = highest set bit of pending. out_last, out_cnt and out_zero unchanged.
- Not defined: lowest-index-first order as above.
- Selected at compile time only; no port or parameter change.

Test Plan:
- Reset: assert rst mid-cycle with in_vec=8'hFF pending -> out_valid=0, in_ready=1, out_cnt=0 immediately, without waiting for a clock edge.
- Basic burst, N=8: accept in_vec=8'b1010_0110, out_ready=1 -> beats out_idx=1,2,5,7; out_last only on idx 7; out_cnt=4 throughout; in_ready=1 on the following cycle. With macro defined: order 7,5,2,1.
- Backpressure: in_vec=8'b0001_0001, out_ready toggling 0,0,1,0,1 -> idx 0 held for 3 cycles, then idx 4 held for 2 cycles; in_ready=0 for the whole burst.
- Zero and full vectors:
  - in_vec=0 -> single beat, out_zero=1, out_idx=0, out_last=1, out_cnt=0.
  - in_vec=8'hFF -> 8 beats, idx 0..7, out_cnt=8.
- Exhaustive sweep, N=4: all 16 vectors back-to-back with random out_ready -> beat sequences match a reference model; no beat is lost or duplicated.
- Reset mid-burst: in_vec=8'b1111_0000, rst after beat idx 4 -> no further beats. Next vector 8'b0000_0010 -> single beat idx 1, out_cnt=1.

Source files
------------

// File: rtl/seq_priority_encoder.sv
// seq_priority_encoder: serializes the index of every set bit of an accepted request vector, one beat per handshake.
// Define SEQ_PRIORITY_ENCODER_MSB_FIRST_EN to emit the highest index first instead of the lowest.
module seq_priority_encoder #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         out_zero,
  output logic [W:0]   out_cnt
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;
  logic [0:0]   state;
  logic [N-1:0] pending;
  logic         zero;
  logic [W:0]   pop;
  logic [W-1:0] idx;
  logic         one_hot;
  always_comb begin
    pop = '0;
    idx = '0;
    for (int i = 0; i < N; i++) pop = pop + (W+1)'(in_vec[i]);
`ifdef SEQ_PRIORITY_ENCODER_MSB_FIRST_EN
    for (int i = 0; i < N; i++) if (pending[i]) idx = W'(i);
`else
    for (int i = N - 1; i >= 0; i--) if (pending[i]) idx = W'(i);
`endif
  end
  // pending is cleared on leaving SCAN, so idx reads 0 in IDLE and for the zero-vector beat
  assign one_hot   = (pending != '0) && ((pending & (pending - N'(1))) == '0);
  assign in_ready  = state == IDLE;
  assign out_valid = state == SCAN;
  assign out_idx   = idx;
  assign out_last  = (state == SCAN) && (zero || one_hot);
  assign out_zero  = (state == SCAN) && zero;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      out_cnt <= '0;
      zero    <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        state   <= SCAN;
        pending <= in_vec;
        out_cnt <= pop;
        zero    <= in_vec == '0;
      end
    end else if (out_ready) begin
      pending <= out_last ? '0 : pending & ~(N'(1) << idx);
      state   <= out_last ? IDLE : SCAN;
      zero    <= out_last ? 1'b0 : zero;
    end
  end
endmodule

// File: tb/tb_seq_priority_encoder.sv
// tb_seq_priority_encoder: scoreboard bench; driver queues expected beats, a negedge monitor pops and compares.
module tb_seq_priority_encoder;
  localparam int N = 8;
  localparam int W = $clog2(N);
  logic clk, rst, in_valid, in_ready, out_valid, out_ready, out_last, out_zero;
  logic [N-1:0] in_vec;
  logic [W-1:0] out_idx;
  logic [W:0]   out_cnt;
  typedef struct {int idx; bit last; bit zero; int cnt;} beat_t;
  beat_t q[$];
  int nt = 0, nf = 0, mt = 0, mf = 0, last_cnt = 0;

  seq_priority_encoder #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_last(out_last), .out_zero(out_zero), .out_cnt(out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    nt++;
    if (act != exp) begin
      nf++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference: list set-bit indices in scan order; an empty vector yields one zero beat
  task automatic expect_vec(input logic [N-1:0] v);
    int ids[$];
    for (int i = 0; i < N; i++)
      if (v[i])
`ifdef SEQ_PRIORITY_ENCODER_MSB_FIRST_EN
        ids.push_front(i);
`else
        ids.push_back(i);
`endif
    last_cnt = ids.size();
    if (ids.size() == 0) q.push_back('{idx: 0, last: 1'b1, zero: 1'b1, cnt: 0});
    else foreach (ids[k]) q.push_back('{idx: ids[k], last: (k == ids.size() - 1), zero: 1'b0, cnt: ids.size()});
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mt++;
      if (in_ready !== !out_valid) begin
        mf++;
        $display("FAIL ready/valid exclusive: in_ready %b out_valid %b", in_ready, out_valid);
      end
      if (out_valid) begin
        mt++;
        if (q.size() == 0) begin
          mf++;
          $display("FAIL spurious beat: idx %0d cnt %0d with nothing expected", out_idx, out_cnt);
        end else begin
          if (int'(out_idx) != q[0].idx || out_last !== q[0].last || out_zero !== q[0].zero || int'(out_cnt) != q[0].cnt) begin
            mf++;
            $display("FAIL beat: got idx %0d last %b zero %b cnt %0d, expected idx %0d last %b zero %b cnt %0d",
                     out_idx, out_last, out_zero, out_cnt, q[0].idx, q[0].last, q[0].zero, q[0].cnt);
          end
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [N-1:0] v, input bit rnd);
    int n = 0;
    bit ok;
    in_vec = v;
    in_valid = 1'b1;
    expect_vec(v);
    do begin
      ok = in_ready;
      if (rnd) out_ready = $urandom_range(0, 3) != 0;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 300);
    in_valid = 1'b0;
    in_vec = N'($urandom);
    chk("accept", int'(ok), 1);
    chk("first beat latency", int'(out_valid), 1);
  endtask

  task automatic drain(input bit rnd);
    int n = 0;
    while ((out_valid || q.size() != 0) && n < 300) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk("drain within budget", int'(n < 300), 1);
    chk("idle in_ready", int'(in_ready), 1);
    chk("out_cnt held after burst", int'(out_cnt), last_cnt);
  endtask

  task automatic abort(input logic [N-1:0] v, input int beats);
    out_ready = 1'b1;
    send(v, 1'b0);
    repeat (beats) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("abort out_valid", int'(out_valid), 0);
    chk("abort in_ready", int'(in_ready), 1);
    chk("abort out_cnt", int'(out_cnt), 0);
    chk("abort out_last", int'(out_last), 0);
    q.delete();
    last_cnt = 0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    drain(1'b0);
  endtask

  initial begin
    automatic int bp_rdy[5] = '{0, 0, 1, 0, 1};
`ifdef SEQ_PRIORITY_ENCODER_MSB_FIRST_EN
    automatic int bp_idx[5] = '{4, 4, 4, 0, 0};
`else
    automatic int bp_idx[5] = '{0, 0, 0, 4, 4};
`endif
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_vec = '0;
    #3;
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_idx", int'(out_idx), 0);
    chk("reset out_last", int'(out_last), 0);
    chk("reset out_zero", int'(out_zero), 0);
    chk("reset out_cnt", int'(out_cnt), 0);
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    send(8'b1010_0110, 1'b0);
    drain(1'b0);
    out_ready = 1'b0;
    send(8'b0001_0001, 1'b0);
    for (int i = 0; i < 5; i++) begin
      out_ready = bp_rdy[i][0];
      chk("backpressure idx", int'(out_idx), bp_idx[i]);
      chk("backpressure in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
    end
    chk("backpressure done", int'(out_valid), 0);
    drain(1'b0);
    send('0, 1'b0);
    drain(1'b0);
    send(8'hFF, 1'b0);
    drain(1'b0);
    abort(8'hFF, 2);
    abort(8'b1111_0000, 1);
    send(8'b0000_0010, 1'b0);
    drain(1'b0);
    for (int v = 0; v < 256; v++) send(N'(v), 1'b1);
    drain(1'b1);
    for (int k = 0; k < 40; k++) send(N'($urandom), 1'b1);
    drain(1'b1);
    chk("scoreboard empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", nt + mt, nf + mf);
    $finish;
  end
endmodule
